// File: rtl/rom_id_table_loader.sv
// rtl/rom_id_table_loader.sv - scans an ID ROM into a local table and answers registered ID lookups
// Scan stops at the sentinel word or when the table is full; lookups only hit once the table is DONE.
module rom_id_table_loader #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 3,
  parameter int                DEPTH    = 8,
  parameter int                RD_LAT   = 2,
  parameter logic [DATA_W-1:0] SENTINEL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] q,
  output logic [ADDR_W-1:0] address,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  input  logic              lookup_valid,
  input  logic [DATA_W-1:0] lookup_id,
  output logic              lookup_hit,
  output logic              lookup_miss,
  output logic [ADDR_W-1:0] lookup_idx
);

  localparam int              LAT_W    = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LAT);
  localparam logic [ADDR_W:0]  DEPTH_C  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {WAIT, CAPTURE, DONE} state_t;

  state_t            state;
  logic [LAT_W-1:0]  lat_cnt;
  logic [DATA_W-1:0] id_table [DEPTH];

  logic              match_found;
  logic [ADDR_W-1:0] match_idx;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (((ADDR_W + 1)'(i) < count) && (id_table[i] == lookup_id)) begin
        match_found = 1'b1;
        match_idx   = ADDR_W'(i);
      end
    end
    if (lookup_id == SENTINEL) begin
      match_found = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= WAIT;
      busy        <= 1'b1;
      done        <= 1'b0;
      address     <= '0;
      count       <= '0;
      lat_cnt     <= LAT_INIT;
      lookup_hit  <= 1'b0;
      lookup_miss <= 1'b0;
      lookup_idx  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        id_table[i] <= SENTINEL;
      end
    end else begin
      // Lookup sees the table as it stood before this edge, even when a reload starts now.
      lookup_hit  <= lookup_valid && (state == DONE) && match_found;
      lookup_miss <= lookup_valid && !((state == DONE) && match_found);
      if (lookup_valid && (state == DONE) && match_found) begin
        lookup_idx <= match_idx;
      end

      case (state)
        WAIT: begin
          if (lat_cnt == '0) begin
            state <= CAPTURE;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        CAPTURE: begin
          if (q == SENTINEL) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            id_table[count[ADDR_W-1:0]] <= q;
            count                       <= count + 1'b1;
            if ((count + 1'b1) == DEPTH_C) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              address <= address + 1'b1;
              lat_cnt <= LAT_INIT;
              state   <= WAIT;
            end
          end
        end
        DONE: begin
          if (start) begin
            count   <= '0;
            address <= '0;
            lat_cnt <= LAT_INIT;
            state   <= WAIT;
            busy    <= 1'b1;
            done    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
              id_table[i] <= SENTINEL;
            end
          end
        end
        default: begin
          state   <= WAIT;
          busy    <= 1'b1;
          done    <= 1'b0;
          lat_cnt <= LAT_INIT;
        end
      endcase
    end
  end

endmodule
